// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel synchronized edge counters serialized onto one round-robin event port
// Optional build macro: EDGE_EVENT_ARB_BOTH_EDGES_EN (falling edges also count as events).
module edge_event_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int PENDING_W = 4,
    parameter int CHAN_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in,
    input  logic [CHANNELS-1:0] clear_overflow,
    output logic                evt_valid,
    output logic [CHAN_W-1:0]   evt_chan,
    input  logic                evt_ready,
    output logic                pending_any,
    output logic [CHANNELS-1:0] overflow
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t               state, state_n;
    logic [2:0]           hist  [CHANNELS];
    logic [PENDING_W-1:0] cnt   [CHANNELS];
    logic [PENDING_W-1:0] cnt_n [CHANNELS];
    logic [CHANNELS-1:0]  edge_det, dec, ovf_set;
    logic [CHAN_W-1:0]    last_grant, last_grant_n, evt_chan_n;
    logic                 accept, any_n, found;
    int                   idx;

    assign evt_valid = (state == OFFER);
    assign accept    = evt_valid && evt_ready;

    always_comb begin
        edge_det = '0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef EDGE_EVENT_ARB_BOTH_EDGES_EN
            edge_det[i] = (hist[i] == 3'b001) || (hist[i] == 3'b110);
`else
            edge_det[i] = (hist[i] == 3'b001);
`endif
        end
    end

    // An edge and an accept on the same channel cancel; a lost edge marks overflow.
    always_comb begin
        dec     = '0;
        ovf_set = '0;
        any_n   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            dec[i]   = accept && (evt_chan == CHAN_W'(i));
            cnt_n[i] = cnt[i];
            if (edge_det[i] && !dec[i]) begin
                if (cnt[i] == {PENDING_W{1'b1}})
                    ovf_set[i] = 1'b1;
                else
                    cnt_n[i] = cnt[i] + 1'b1;
            end else if (dec[i] && !edge_det[i]) begin
                cnt_n[i] = cnt[i] - 1'b1;
            end
            any_n = any_n | (cnt_n[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_any <= 1'b0;
            overflow    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                hist[i] <= '0;
                cnt[i]  <= '0;
            end
        end else begin
            pending_any <= any_n;
            overflow    <= ovf_set | (overflow & ~clear_overflow);
            for (int i = 0; i < CHANNELS; i++) begin
                hist[i] <= {hist[i][1:0], in[i]};
                cnt[i]  <= cnt_n[i];
            end
        end
    end

    // Scan starts just after the last granted channel, giving rotating priority.
    always_comb begin
        state_n      = state;
        evt_chan_n   = evt_chan;
        last_grant_n = last_grant;
        found        = 1'b0;
        idx          = 0;
        case (state)
            IDLE: begin
                for (int off = 1; off <= CHANNELS; off++) begin
                    idx = int'(last_grant) + off;
                    if (idx >= CHANNELS)
                        idx = idx - CHANNELS;
                    if (!found && (cnt[idx] != '0)) begin
                        found      = 1'b1;
                        evt_chan_n = CHAN_W'(idx);
                        state_n    = OFFER;
                    end
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    state_n      = IDLE;
                    last_grant_n = evt_chan;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            evt_chan   <= '0;
            last_grant <= CHAN_W'(CHANNELS - 1);
        end else begin
            state      <= state_n;
            evt_chan   <= evt_chan_n;
            last_grant <= last_grant_n;
        end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter (CHANNELS=4, PENDING_W=2)
module tb_edge_event_arbiter;
    localparam int CH   = 4;
    localparam int PW   = 2;
    localparam int CW   = 2;
    localparam int MAXC = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in_d = '0;
    logic [CH-1:0] clr = '0;
    logic          ready = 1'b0;
    logic          evt_valid;
    logic [CW-1:0] evt_chan;
    logic          pending_any;
    logic [CH-1:0] overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: recent samples per channel, pending counts, offer state.
    bit ms [CH][3];
    int mcnt [CH];
    bit movf [CH];
    bit mvalid;
    int mchan;
    int mlast;
    bit mpany;

    edge_event_arbiter #(.CHANNELS(CH), .PENDING_W(PW)) dut (
        .clk(clk), .reset(rst), .in(in_d), .clear_overflow(clr),
        .evt_valid(evt_valid), .evt_chan(evt_chan), .evt_ready(ready),
        .pending_any(pending_any), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            ms[c][0] = 0; ms[c][1] = 0; ms[c][2] = 0;
            mcnt[c] = 0; movf[c] = 0;
        end
        mvalid = 0; mchan = 0; mlast = CH - 1; mpany = 0;
    endtask

    function automatic bit m_event(int c);
        bit r;
        r = ms[c][0] && !ms[c][1] && !ms[c][2];
`ifdef EDGE_EVENT_ARB_BOTH_EDGES_EN
        r = r || (!ms[c][0] && ms[c][1] && ms[c][2]);
`endif
        return r;
    endfunction

    task automatic tick();
        int  newc [CH];
        bit  acc, ev, dc, found;
        int  c;
        @(posedge clk);
        if (!rst) begin
            acc = mvalid && ready;
            for (int k = 0; k < CH; k++) begin
                ev = m_event(k);
                dc = acc && (mchan == k);
                newc[k] = mcnt[k];
                if (ev && !dc) begin
                    if (mcnt[k] == MAXC) movf[k] = 1;
                    else newc[k] = mcnt[k] + 1;
                end else if (dc && !ev) begin
                    newc[k] = mcnt[k] - 1;
                end else if (clr[k] && !(ev && !dc && mcnt[k] == MAXC)) begin
                    movf[k] = 0;
                end
                if (ev && !dc && mcnt[k] == MAXC) movf[k] = 1;
                else if (clr[k]) movf[k] = 0;
            end
            if (mvalid) begin
                if (ready) begin mvalid = 0; mlast = mchan; end
            end else begin
                found = 0;
                for (int off = 1; off <= CH; off++) begin
                    c = (mlast + off) % CH;
                    if (!found && mcnt[c] > 0) begin found = 1; mvalid = 1; mchan = c; end
                end
            end
            mpany = 0;
            for (int k = 0; k < CH; k++) begin
                mcnt[k] = newc[k];
                if (newc[k] != 0) mpany = 1;
                ms[k][2] = ms[k][1]; ms[k][1] = ms[k][0]; ms[k][0] = in_d[k];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_d = '0; clr = '0; ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        int offers = 0;
        do_reset();
        n_vec++;
        if ({evt_valid, evt_chan, pending_any, overflow} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b c=%0d p=%0b o=%0h required all zero", evt_valid, evt_chan, pending_any, overflow);
        end
        rst = 1; in_d = 4'b0001;
        repeat (2) @(posedge clk);
        #1 rst = 0; ready = 1;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (evt_valid && evt_chan == 0) offers++;
        end
        n_vec++;
        if (offers != 1) begin
            n_err++;
            $display("FAIL high_across_reset: got %0d offers required 1", offers);
        end
        in_d = '0;
    endtask

    task automatic test_single_event();
        do_reset();
        ready = 1; in_d = 4'b0100;
        tick(); in_d = '0;
        n_vec++;
        if (evt_valid !== 1'b0) begin n_err++; $display("FAIL single_k: got valid=%0b required 0", evt_valid); end
        tick();
        n_vec++;
        if ({evt_valid, pending_any} !== 2'b01) begin n_err++; $display("FAIL single_k1: got v/p=%b%b required 01", evt_valid, pending_any); end
        tick();
        n_vec++;
        if ({evt_valid, evt_chan} !== {1'b1, 2'd2}) begin n_err++; $display("FAIL single_k2: got v=%0b c=%0d required v=1 c=2", evt_valid, evt_chan); end
        tick();
        n_vec++;
        if ({evt_valid, pending_any} !== 2'b00) begin n_err++; $display("FAIL single_k3: got v/p=%b%b required 00", evt_valid, pending_any); end
    endtask

    task automatic test_round_robin();
        bit exp_v;
        do_reset();
        ready = 1; in_d = 4'hF;
        tick(); in_d = '0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_v = (t >= 2) && (t <= 8) && (t % 2 == 0);
            n_vec++;
            if (evt_valid !== exp_v || (exp_v && evt_chan !== CW'((t - 2) / 2))) begin
                n_err++;
                $display("FAIL round_robin t=%0d: got v=%0b c=%0d required v=%0b c=%0d", t, evt_valid, evt_chan, exp_v, (t - 2) / 2);
            end
        end
    endtask

    task automatic test_back_pressure();
        int offers = 0;
        bit pat [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
        do_reset();
        for (int t = 0; t < 20; t++) begin
            in_d = (t < 9) ? {2'b00, pat[t], 1'b0} : '0;
            tick();
            if (t >= 2) begin
                n_vec++;
                if (evt_valid !== 1'b1 || evt_chan !== 2'd1) begin
                    n_err++;
                    $display("FAIL backpressure_hold t=%0d: got v=%0b c=%0d required v=1 c=1", t, evt_valid, evt_chan);
                end
            end
        end
        in_d = '0; ready = 1;
        for (int t = 0; t < 20; t++) begin
            if (evt_valid && evt_chan == 1) offers++;
            tick();
        end
        n_vec++;
        if (offers != 3 || pending_any !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_count: got offers=%0d p=%0b required offers=3 p=0", offers, pending_any);
        end
    endtask

    task automatic test_saturation();
        int offers = 0;
        do_reset();
        for (int t = 0; t < 17; t++) begin
            in_d = (t < 15 && t % 3 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        n_vec++;
        if (overflow !== 4'b0001) begin n_err++; $display("FAIL sat_overflow: got %b required 0001", overflow); end
        in_d = 4'b0001; tick();
        in_d = '0; clr = 4'b0001; tick();
        clr = '0;
        n_vec++;
        if (overflow[0] !== 1'b1) begin n_err++; $display("FAIL sat_set_priority: got %b required 1", overflow[0]); end
        tick(); tick();
        clr = 4'b0001; tick(); clr = '0;
        n_vec++;
        if (overflow !== 4'b0000) begin n_err++; $display("FAIL sat_clear: got %b required 0000", overflow); end
        ready = 1;
        for (int t = 0; t < 16; t++) begin
            if (evt_valid && evt_chan == 0) offers++;
            tick();
        end
        n_vec++;
        if (offers != MAXC) begin n_err++; $display("FAIL sat_drain: got %0d offers required %0d", offers, MAXC); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        in_d = 4'b1000; tick();
        in_d = '0; tick(); tick();
        in_d = 4'b1000; tick();
        in_d = '0; ready = 1; tick();
        n_vec++;
        if ({evt_valid, pending_any} !== 2'b01) begin n_err++; $display("FAIL simul_bubble: got v/p=%b%b required 01", evt_valid, pending_any); end
        tick();
        n_vec++;
        if ({evt_valid, evt_chan} !== {1'b1, 2'd3}) begin n_err++; $display("FAIL simul_reoffer: got v=%0b c=%0d required v=1 c=3", evt_valid, evt_chan); end
        tick();
        n_vec++;
        if ({evt_valid, pending_any} !== 2'b00) begin n_err++; $display("FAIL simul_drain: got v/p=%b%b required 00", evt_valid, pending_any); end
    endtask

    task automatic test_both_edges();
        int offers = 0;
        int expect_n;
`ifdef EDGE_EVENT_ARB_BOTH_EDGES_EN
        expect_n = 2;
`else
        expect_n = 1;
`endif
        do_reset();
        ready = 1;
        for (int t = 0; t < 24; t++) begin
            in_d = (t < 10) ? 4'b0001 : 4'b0000;
            tick();
            if (evt_valid && evt_chan == 0) offers++;
        end
        n_vec++;
        if (offers != expect_n) begin n_err++; $display("FAIL both_edges: got %0d events required %0d", offers, expect_n); end
    endtask

    task automatic test_reset_mid_offer();
        bit seen = 0;
        do_reset();
        in_d = 4'b0010; tick();
        in_d = '0; tick(); tick();
        n_vec++;
        if (evt_valid !== 1'b1) begin n_err++; $display("FAIL mid_offer_setup: got v=%0b required 1", evt_valid); end
        #2 rst = 1;
        #1;
        n_vec++;
        if ({evt_valid, evt_chan, pending_any} !== '0) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b c=%0d p=%0b required zeros", evt_valid, evt_chan, pending_any);
        end
        @(posedge clk);
        #1 rst = 0; model_reset(); ready = 1;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (evt_valid) seen = 1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL reset_discard: got an offer required none"); end
    endtask

    task automatic test_random();
        int rp;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            rp = (t / 500) % 3;
            in_d  = CH'($urandom);
            ready = (rp == 0) ? ($urandom_range(0, 7) == 0) : (rp == 1) ? ($urandom_range(0, 1) == 0) : 1'b1;
            clr   = ($urandom_range(0, 9) == 0) ? CH'($urandom) : '0;
            tick();
            n_vec++;
            if (evt_valid !== mvalid || evt_chan !== CW'(mchan) || pending_any !== mpany ||
                overflow !== {movf[3], movf[2], movf[1], movf[0]}) begin
                n_err++;
                $display("FAIL random t=%0d: got v=%0b c=%0d p=%0b o=%b required v=%0b c=%0d p=%0b o=%b", t,
                         evt_valid, evt_chan, pending_any, overflow, mvalid, mchan, mpany,
                         {movf[3], movf[2], movf[1], movf[0]});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_event();
        test_round_robin();
        test_back_pressure();
        test_saturation();
        test_simultaneous();
        test_both_edges();
        test_reset_mid_offer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
